// File: rtl/uart_mat_xfer_pkg.sv
// Shared state encoding, host command bytes and bank addressing for uart_mat_xfer_fsm.
package uart_mat_xfer_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HDR_R     = 4'd1,
        S_HDR_C     = 4'd2,
        S_LOAD      = 4'd3,
        S_CHECK     = 4'd4,
        S_WAIT_CALC = 4'd5,
        S_RES_RD    = 4'd6,
        S_RES_TX    = 4'd7,
        S_ERR_TX    = 4'd8
    } state_e;

    localparam logic [7:0] CMD_LOAD_A = 8'hA0;
    localparam logic [7:0] CMD_LOAD_W = 8'hB0;
    localparam logic [7:0] CMD_READ_C = 8'hC0;
    localparam logic [7:0] ERR_BYTE   = 8'hEE;

    // r is the row index inside its bank (global row / NUM_BANKS).
    function automatic logic [31:0] bank_addr(input logic [31:0] r, input logic [31:0] c,
                                              input logic [31:0] cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/uart_mat_xfer_fsm_packer.sv
// byte_word_packer: gathers BYTES bytes LSB-first into one DATA_W word; word_vld marks the last byte.
module byte_word_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [7:0]        in_byte,
    output logic              word_vld,
    output logic [DATA_W-1:0] word
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] shifted;
    logic              last;

    generate
        if (BYTES == 1) begin : g_one
            assign shifted = in_byte;
        end else begin : g_multi
            assign shifted = {in_byte, data_q[DATA_W-1:8]};
        end
    endgenerate

    assign last     = (idx_q == IDX_W'(BYTES - 1));
    assign word_vld = in_vld && !clr && last;
    assign word     = shifted;

    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        if (clr) begin
            idx_d = '0;
        end else if (in_vld) begin
            data_d = shifted;
            idx_d  = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/uart_mat_xfer_fsm.sv
// Host-side UART command FSM: loads A/W into banked RAMs, hands off to the core, streams C back.
// Optional UART_MAT_XFER_CHECKSUM_EN adds an XOR checksum byte to every load and result stream.
module uart_mat_xfer_fsm
    import uart_mat_xfer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NUM_BANKS = 2,
    parameter int MAX_DIM   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx_done,
    input  logic [7:0]           uart_rx_data,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_send_data,
    input  logic                 uart_tx_done,
    output logic [ADDR_W-1:0]    ram_wr_addr,
    output logic [DATA_W-1:0]    ram_wr_data,
    output logic [NUM_BANKS-1:0] ram_a_wren,
    output logic [NUM_BANKS-1:0] ram_w_wren,
    output logic                 data_load_done,
    input  logic                 calc_done,
    output logic [ADDR_W-1:0]    ram_c_addr,
    input  logic [DATA_W-1:0]    ram_c_data,
    output logic                 data_response_done,
    output logic                 fsm_working,
    output logic [6:0]           a_rows,
    output logic [6:0]           a_cols,
    output logic [6:0]           w_rows,
    output logic [6:0]           w_cols,
    output logic [3:0]           state_val
);
    localparam int BYTES   = DATA_W / 8;
    localparam int BI_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W   = $clog2(MAX_DIM * MAX_DIM + 1);
    localparam int BANK_SH = $clog2(NUM_BANKS);

    state_e                state_q, state_d;
    logic                  tgt_w_q, tgt_w_d;
    logic [6:0]            a_rows_q, a_rows_d, a_cols_q, a_cols_d;
    logic [6:0]            w_rows_q, w_rows_d, w_cols_q, w_cols_d;
    logic                  a_loaded_q, a_loaded_d, w_loaded_q, w_loaded_d;
    logic                  calc_seen_q, calc_seen_d;
    logic [6:0]            r_q, r_d, c_q, c_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [BI_W-1:0]       byte_idx_q, byte_idx_d;
    logic                  sent_q, sent_d;
    logic [DATA_W-1:0]     tx_word_q, tx_word_d;
    logic                  resp_done_q, resp_done_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic [NUM_BANKS-1:0]  a_wren_q, a_wren_d, w_wren_q, w_wren_d;
`ifdef UART_MAT_XFER_CHECKSUM_EN
    logic [7:0]            rx_csum_q, rx_csum_d, tx_csum_q, tx_csum_d;
    logic                  ck_phase_q, ck_phase_d;
`endif

    logic [6:0]            rows_cur, cols_cur;
    logic [CNT_W-1:0]      n_words;
    logic [DATA_W-1:0]     cur_word;
    logic                  pk_clr, pk_vld, pk_word_vld;
    logic [DATA_W-1:0]     pk_word;

    byte_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pk_clr),
        .in_vld   (pk_vld),
        .in_byte  (uart_rx_data),
        .word_vld (pk_word_vld),
        .word     (pk_word)
    );

    assign rows_cur = tgt_w_q ? w_rows_q : a_rows_q;
    assign cols_cur = tgt_w_q ? w_cols_q : a_cols_q;
    assign n_words  = CNT_W'(a_rows_q) * CNT_W'(w_cols_q);
    // Byte 0 of a word comes straight off the RAM; later bytes from the captured copy.
    assign cur_word = (byte_idx_q == '0) ? ram_c_data : tx_word_q;

    always_comb begin
        state_d = state_q;  tgt_w_d = tgt_w_q;
        a_rows_d = a_rows_q;  a_cols_d = a_cols_q;  w_rows_d = w_rows_q;  w_cols_d = w_cols_q;
        a_loaded_d = a_loaded_q;  w_loaded_d = w_loaded_q;  calc_seen_d = calc_seen_q;
        r_d = r_q;  c_d = c_q;  word_cnt_d = word_cnt_q;  byte_idx_d = byte_idx_q;
        sent_d = sent_q;  tx_word_d = tx_word_q;  resp_done_d = 1'b0;
        wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;  a_wren_d = '0;  w_wren_d = '0;
        uart_send_data = 1'b0;  uart_tx_data = 8'h00;  data_load_done = 1'b0;
        pk_clr = 1'b0;  pk_vld = 1'b0;
`ifdef UART_MAT_XFER_CHECKSUM_EN
        rx_csum_d = rx_csum_q;  tx_csum_d = tx_csum_q;  ck_phase_d = ck_phase_q;
`endif
        case (state_q)
            S_IDLE: if (uart_rx_done) begin
                if (uart_rx_data == CMD_LOAD_A) begin
                    tgt_w_d = 1'b0;  a_loaded_d = 1'b0;  state_d = S_HDR_R;
                end else if (uart_rx_data == CMD_LOAD_W) begin
                    tgt_w_d = 1'b1;  w_loaded_d = 1'b0;  state_d = S_HDR_R;
                end else if (uart_rx_data == CMD_READ_C) begin
                    word_cnt_d = '0;  byte_idx_d = '0;
                    state_d = calc_seen_q ? S_RES_RD : S_ERR_TX;
                end
            end
            S_HDR_R, S_HDR_C: if (uart_rx_done) begin
                if (uart_rx_data == 8'd0 || uart_rx_data > 8'(MAX_DIM)) begin
                    state_d = S_ERR_TX;
                end else if (state_q == S_HDR_R) begin
                    if (tgt_w_q) w_rows_d = 7'(uart_rx_data); else a_rows_d = 7'(uart_rx_data);
                    state_d = S_HDR_C;
                end else begin
                    if (tgt_w_q) w_cols_d = 7'(uart_rx_data); else a_cols_d = 7'(uart_rx_data);
                    r_d = '0;  c_d = '0;  pk_clr = 1'b1;  state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef UART_MAT_XFER_CHECKSUM_EN
                if (ck_phase_q) begin
                    if (uart_rx_done) begin
                        if (uart_rx_data == rx_csum_q) begin
                            if (tgt_w_q) w_loaded_d = 1'b1; else a_loaded_d = 1'b1;
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_ERR_TX;
                        end
                    end
                end else
`endif
                begin
                    pk_vld = uart_rx_done;
                    if (pk_word_vld) begin
                        wr_addr_d = ADDR_W'(bank_addr(32'(r_q >> BANK_SH), 32'(c_q), 32'(cols_cur)));
                        wr_data_d = pk_word;
                        if (tgt_w_q) w_wren_d = NUM_BANKS'(1) << (r_q % NUM_BANKS);
                        else         a_wren_d = NUM_BANKS'(1) << (r_q % NUM_BANKS);
                        c_d = (c_q == cols_cur - 7'd1) ? 7'd0 : c_q + 7'd1;
                        r_d = (c_q == cols_cur - 7'd1) ? r_q + 7'd1 : r_q;
                        if (r_q == rows_cur - 7'd1 && c_q == cols_cur - 7'd1) begin
`ifdef UART_MAT_XFER_CHECKSUM_EN
                            ck_phase_d = 1'b1;
`else
                            if (tgt_w_q) w_loaded_d = 1'b1; else a_loaded_d = 1'b1;
                            state_d = S_CHECK;
`endif
                        end
                    end
                end
            end
            S_CHECK: begin
                if (a_loaded_q && w_loaded_q) begin
                    if (a_cols_q != w_rows_q) begin
                        state_d = S_ERR_TX;
                    end else begin
                        data_load_done = 1'b1;  state_d = S_WAIT_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_CALC: if (calc_done) begin
                calc_seen_d = 1'b1;  state_d = S_IDLE;
            end
            S_RES_RD: state_d = S_RES_TX;
            S_RES_TX: begin
`ifdef UART_MAT_XFER_CHECKSUM_EN
                if (ck_phase_q) begin
                    if (!sent_q) begin
                        uart_send_data = 1'b1;  uart_tx_data = tx_csum_q;  sent_d = 1'b1;
                    end
                    if (uart_tx_done && sent_q) begin
                        resp_done_d = 1'b1;  a_loaded_d = 1'b0;  w_loaded_d = 1'b0;
                        calc_seen_d = 1'b0;  state_d = S_IDLE;
                    end
                end else
`endif
                begin
                    if (!sent_q) begin
                        uart_send_data = 1'b1;
                        uart_tx_data   = 8'(cur_word >> {byte_idx_q, 3'b000});
                        sent_d         = 1'b1;
                        if (byte_idx_q == '0) tx_word_d = ram_c_data;
                    end
                    if (uart_tx_done && sent_q) begin
                        if (byte_idx_q == BI_W'(BYTES - 1)) begin
                            byte_idx_d = '0;
                            if (word_cnt_q == n_words - 1'b1) begin
`ifdef UART_MAT_XFER_CHECKSUM_EN
                                ck_phase_d = 1'b1;  sent_d = 1'b0;
`else
                                resp_done_d = 1'b1;  a_loaded_d = 1'b0;  w_loaded_d = 1'b0;
                                calc_seen_d = 1'b0;  state_d = S_IDLE;
`endif
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;  state_d = S_RES_RD;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;  sent_d = 1'b0;
                        end
                    end
                end
            end
            S_ERR_TX: begin
                a_loaded_d = 1'b0;  w_loaded_d = 1'b0;
                if (!sent_q) begin
                    uart_send_data = 1'b1;  uart_tx_data = ERR_BYTE;  sent_d = 1'b1;
                end
                if (uart_tx_done && sent_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef UART_MAT_XFER_CHECKSUM_EN
        // Load checksum covers the command, both header bytes and all element bytes.
        if (uart_rx_done) begin
            if (state_q == S_IDLE)
                rx_csum_d = uart_rx_data;
            else if (state_q == S_HDR_R || state_q == S_HDR_C || (state_q == S_LOAD && !ck_phase_q))
                rx_csum_d = rx_csum_q ^ uart_rx_data;
        end
        if (state_q == S_IDLE) tx_csum_d = '0;
        else if (state_q == S_RES_TX && uart_send_data && !ck_phase_q) tx_csum_d = tx_csum_q ^ uart_tx_data;
`endif
        if (state_d != state_q) begin
            sent_d = 1'b0;
`ifdef UART_MAT_XFER_CHECKSUM_EN
            ck_phase_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  tgt_w_q <= 1'b0;
            a_rows_q <= '0;  a_cols_q <= '0;  w_rows_q <= '0;  w_cols_q <= '0;
            a_loaded_q <= 1'b0;  w_loaded_q <= 1'b0;  calc_seen_q <= 1'b0;
            r_q <= '0;  c_q <= '0;  word_cnt_q <= '0;  byte_idx_q <= '0;
            sent_q <= 1'b0;  tx_word_q <= '0;  resp_done_q <= 1'b0;
            wr_addr_q <= '0;  wr_data_q <= '0;  a_wren_q <= '0;  w_wren_q <= '0;
`ifdef UART_MAT_XFER_CHECKSUM_EN
            rx_csum_q <= '0;  tx_csum_q <= '0;  ck_phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;  tgt_w_q <= tgt_w_d;
            a_rows_q <= a_rows_d;  a_cols_q <= a_cols_d;  w_rows_q <= w_rows_d;  w_cols_q <= w_cols_d;
            a_loaded_q <= a_loaded_d;  w_loaded_q <= w_loaded_d;  calc_seen_q <= calc_seen_d;
            r_q <= r_d;  c_q <= c_d;  word_cnt_q <= word_cnt_d;  byte_idx_q <= byte_idx_d;
            sent_q <= sent_d;  tx_word_q <= tx_word_d;  resp_done_q <= resp_done_d;
            wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;  a_wren_q <= a_wren_d;  w_wren_q <= w_wren_d;
`ifdef UART_MAT_XFER_CHECKSUM_EN
            rx_csum_q <= rx_csum_d;  tx_csum_q <= tx_csum_d;  ck_phase_q <= ck_phase_d;
`endif
        end
    end

    assign ram_wr_addr        = wr_addr_q;
    assign ram_wr_data        = wr_data_q;
    assign ram_a_wren         = a_wren_q;
    assign ram_w_wren         = w_wren_q;
    assign ram_c_addr         = ADDR_W'(word_cnt_q);
    assign data_response_done = resp_done_q;
    assign fsm_working        = (state_q != S_IDLE);
    assign a_rows             = a_rows_q;
    assign a_cols             = a_cols_q;
    assign w_rows             = w_rows_q;
    assign w_cols             = w_cols_q;
    assign state_val          = state_q;

endmodule
